pmem_line_arbiter: RTL and testbench
====================================

// Module: pmem_line_arbiter
// PURPOSE
//  Sits directly downstream of the pipelined I-cache and D-cache. Arbitrates their
//  256-bit line requests onto the single physical-memory line port. Requests and
//  responses are registered; read data is returned to the granted cache only.
//  Round-robin grant on contention, so neither cache starves.
// PARAMETERS
//  s_offset  5    line offset bits; low s_offset address bits are forced to 0 on the memory port
//  s_line    256  line width in bits
// PORTS
//  clk              in   1       system clock
//  rst              in   1       asynchronous, active-low reset
//  i_pmem_read      in   1       I-cache line read request; held until i_pmem_resp
//  i_pmem_address   in   32      I-cache request address
//  i_pmem_resp      out  1       one-cycle completion pulse to the I-cache
//  i_pmem_rdata     out  s_line  line returned to the I-cache; valid while i_pmem_resp=1
//  d_pmem_read      in   1       D-cache line read request; held until d_pmem_resp
//  d_pmem_write     in   1       D-cache line write-back request; held until d_pmem_resp
//  d_pmem_address   in   32      D-cache request address
//  d_pmem_wdata     in   s_line  D-cache write-back line
//  d_pmem_resp      out  1       one-cycle completion pulse to the D-cache
//  d_pmem_rdata     out  s_line  line returned to the D-cache; valid while d_pmem_resp=1
//  mem_read         out  1       memory-port read request
//  mem_write        out  1       memory-port write request
//  mem_address      out  32      memory-port address, line aligned
//  mem_wdata        out  s_line  memory-port write line
//  mem_resp         in   1       memory-port completion, single-cycle pulse
//  mem_rdata        in   s_line  memory-port read line; valid with mem_resp
// BEHAVIOUR
//  - States are IDLE, BUSY_I, BUSY_D and RESP. Two flops hold the owner (I/D) and last_grant.
//  - Reset (rst=0, async) drives all outputs to 0 and the state to IDLE. last_grant resets to I,
//    so the D-cache wins the first tie. The line register clears to 0.
//  - IDLE with only one side requesting: grant that side.
//  - IDLE with both sides requesting: grant the side opposite to last_grant.
//    On the grant edge, latch the address (low s_offset bits zeroed), wdata and op;
//    set last_grant; go to BUSY_x.
//  - If d_pmem_read and d_pmem_write are both high, the request is treated as a write.
//  - BUSY_x drives mem_read or mem_write plus the latched address/wdata from registers.
//    These stay stable until mem_resp. Input changes during BUSY are ignored.
//  - BUSY_x with mem_resp=1: capture mem_rdata into the line register, drop mem_read/mem_write
//    on the same edge, go to RESP.
//  - RESP lasts exactly one cycle. It asserts x_pmem_resp for the owner only and drives
//    x_pmem_rdata from the line register. The other side's resp stays 0. Next state is IDLE.
//  - Latency: request seen at edge t -> mem_read/write high from t+1 -> mem_resp at edge m
//    -> client resp high in cycle m+1. With 0-wait memory that is 3 cycles. Min gap between grants: 1 IDLE cycle.
//  - mem_resp in IDLE or RESP is a protocol error and is ignored: no state change, no resp.
//  - The non-owner's rdata output is held at the last captured line; its resp is never asserted.
//  - Reset mid-transaction abandons it: no client resp, memory request dropped immediately.
//    A late mem_resp after reset is ignored by the IDLE rule.
// TESTING
//  - Reset: hold rst=0 then release -> all outputs 0, state IDLE; d-side wins the first tie.
//  - Lone I read of 0x0000_104C, memory replies 2 cycles later with 0xA5..A5:
//    mem_address=0x0000_1040; i_pmem_resp=1 for exactly 1 cycle; i_pmem_rdata=0xA5..A5; d_pmem_resp=0.
//  - I read and D write asserted in the same cycle:
//    D granted first (mem_write, wdata passed through); then I served;
//    third simultaneous pair -> D granted (strict alternation).
//  - d_pmem_read=d_pmem_write=1 -> only mem_write asserts; d_pmem_resp pulses once.
//  - Pulse rst=0 while BUSY_D, then mem_resp arrives afterwards:
//    mem_read/mem_write fall asynchronously; no resp to either cache; state IDLE.
//  - Spurious mem_resp in IDLE -> no resp outputs, grants unaffected.

Source files
------------

// File: rtl/pmem_line_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_line_arbiter
//   Shares one physical-memory line port between the I-cache and the D-cache.
//   A request is granted from IDLE, its address, write line and operation are
//   latched, and the memory port is driven from those registers until mem_resp.
//   The returned line is captured. The completion pulse goes to the owning cache
//   only, one cycle after mem_resp. Round-robin on contention; the D-cache wins
//   the first tie after reset.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   i_pmem_read/address   I-cache line read request (held until i_pmem_resp)
//   i_pmem_resp/rdata     I-cache completion pulse and returned line
//   d_pmem_read/write     D-cache line read / write-back request (held until resp)
//   d_pmem_address/wdata  D-cache request address and write-back line
//   d_pmem_resp/rdata     D-cache completion pulse and returned line
//   mem_read/write        memory-port request (stable until mem_resp)
//   mem_address/wdata     memory-port line-aligned address and write line
//   mem_resp/rdata        memory-port single-cycle completion and read line
// -----------------------------------------------------------------------------
module pmem_line_arbiter #(
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [31:0]       i_pmem_address,
    output logic              i_pmem_resp,
    output logic [s_line-1:0] i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [31:0]       d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [s_line-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [s_line-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              last_grant;
    logic              op_write;
    logic [31:0]       addr_q;
    logic [s_line-1:0] wdata_q;
    logic [s_line-1:0] line_q;

    logic              i_req;
    logic              d_req;
    logic              grant;
    logic              grant_d;
    logic              busy;

    function automatic logic [31:0] line_align(input logic [31:0] a);
        return {a[31:s_offset], {s_offset{1'b0}}};
    endfunction

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;
    assign busy  = (state == BUSY_I) || (state == BUSY_D);

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_d   = 1'b0;
        unique case (state)
            IDLE: begin
                // D wins when alone, or on a tie when I was granted last.
                if (d_req && (!i_req || last_grant == OWN_I)) begin
                    grant     = 1'b1;
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (i_req) begin
                    grant     = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_resp) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            op_write   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            line_q     <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner      <= grant_d;
                last_grant <= grant_d;
                // A simultaneous read+write from the D-cache is a write-back.
                op_write   <= grant_d & d_pmem_write;
                addr_q     <= grant_d ? line_align(d_pmem_address)
                                      : line_align(i_pmem_address);
                if (grant_d) wdata_q <= d_pmem_wdata;
            end
            if (busy && mem_resp) line_q <= mem_rdata;
        end
    end

    // Memory request is decoded from the state flop so an async reset drops it at once.
    assign mem_read    = busy & ~op_write;
    assign mem_write   = busy & op_write;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

    assign i_pmem_resp  = (state == RESP) && (owner == OWN_I);
    assign d_pmem_resp  = (state == RESP) && (owner == OWN_D);
    assign i_pmem_rdata = line_q;
    assign d_pmem_rdata = line_q;

endmodule

// File: tb/tb_pmem_line_arbiter.sv
module tb_pmem_line_arbiter;

    logic         clk;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic         i_pmem_resp;
    logic [255:0] i_pmem_rdata;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic         d_pmem_resp;
    logic [255:0] d_pmem_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic         mem_resp;
    logic [255:0] mem_rdata;

    int n_checks;
    int n_fail;

    localparam logic [255:0] LINE_A5 = {8{32'hA5A5_A5A5}};
    localparam logic [255:0] W1      = {8{32'h1111_0001}};
    localparam logic [255:0] W3      = {8{32'h3333_0003}};
    localparam logic [255:0] R1      = {8{32'hC0DE_0001}};
    localparam logic [255:0] R2      = {8{32'hC0DE_0002}};
    localparam logic [255:0] R3      = {8{32'hC0DE_0003}};
    localparam logic [255:0] R4      = {8{32'hC0DE_0004}};
    localparam logic [255:0] R5      = {8{32'hC0DE_0005}};
    localparam logic [255:0] R6      = {8{32'hC0DE_0006}};
    localparam logic [255:0] JUNK    = {8{32'hDEAD_BEEF}};

    pmem_line_arbiter #(.s_offset(5), .s_line(256)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one granted transaction: check the memory port, reply immediately,
    // check the one-cycle completion to the owner, and drop the owner's request.
    task automatic serve(input string tag, input logic exp_d, input logic exp_wr,
                         input logic [31:0] exp_addr, input logic [255:0] exp_wdata,
                         input logic [255:0] rdata);
        int waited;
        waited = 0;
        while (!(mem_read || mem_write) && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) begin
            chk_eq({tag, "_timeout"}, 256'd0, 256'd1);
            return;
        end
        chk_eq({tag, "_mem_write"}, 256'(mem_write), 256'(exp_wr));
        chk_eq({tag, "_mem_read"},  256'(mem_read),  256'(!exp_wr));
        chk_eq({tag, "_mem_addr"},  256'(mem_address), 256'(exp_addr));
        if (exp_wr) chk_eq({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = JUNK;
        chk_eq({tag, "_i_resp"}, 256'(i_pmem_resp), 256'(!exp_d));
        chk_eq({tag, "_d_resp"}, 256'(d_pmem_resp), 256'(exp_d));
        chk_eq({tag, "_rdata"}, exp_d ? d_pmem_rdata : i_pmem_rdata, rdata);
        chk_eq({tag, "_other_rdata"}, exp_d ? i_pmem_rdata : d_pmem_rdata, rdata);
        chk_eq({tag, "_req_dropped"}, 256'(mem_read | mem_write), 256'd0);
        if (exp_d) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end else begin
            i_pmem_read  = 1'b0;
        end
        tick();
        chk_eq({tag, "_resp_one_cycle"}, 256'(i_pmem_resp | d_pmem_resp), 256'd0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b0;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        mem_resp       = 1'b0;
        mem_rdata      = '0;

        // Reset
        tick();
        tick();
        chk_eq("rst_mem_rw",  256'({mem_read, mem_write}), 256'd0);
        chk_eq("rst_resp",    256'({i_pmem_resp, d_pmem_resp}), 256'd0);
        chk_eq("rst_addr",    256'(mem_address), 256'd0);
        chk_eq("rst_wdata",   mem_wdata, 256'd0);
        chk_eq("rst_rdata",   i_pmem_rdata | d_pmem_rdata, 256'd0);
        rst = 1'b1;
        tick();
        chk_eq("post_rst_idle", 256'({mem_read, mem_write, i_pmem_resp, d_pmem_resp}), 256'd0);

        // Lone I read, memory replies 2 cycles after the request appears
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_104C;
        tick();
        chk_eq("lone_i_mem_read",  256'(mem_read), 256'd1);
        chk_eq("lone_i_mem_write", 256'(mem_write), 256'd0);
        chk_eq("lone_i_addr",      256'(mem_address), 256'(32'h0000_1040));
        i_pmem_address = 32'hFFFF_FFFF;
        tick();
        chk_eq("lone_i_addr_stable", 256'(mem_address), 256'(32'h0000_1040));
        chk_eq("lone_i_no_resp_yet", 256'(i_pmem_resp), 256'd0);
        mem_resp  = 1'b1;
        mem_rdata = LINE_A5;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = JUNK;
        chk_eq("lone_i_resp",   256'(i_pmem_resp), 256'd1);
        chk_eq("lone_i_d_resp", 256'(d_pmem_resp), 256'd0);
        chk_eq("lone_i_rdata",  i_pmem_rdata, LINE_A5);
        chk_eq("lone_i_mem_drop", 256'(mem_read), 256'd0);
        i_pmem_read = 1'b0;
        tick();
        chk_eq("lone_i_resp_1cyc", 256'(i_pmem_resp), 256'd0);

        // Simultaneous I read and D write: D first (last_grant=I), then I
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h2000_0004;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h3000_003F;
        d_pmem_wdata   = W1;
        tick();
        serve("tie1_d", 1'b1, 1'b1, 32'h3000_0020, W1, R1);
        tick();
        serve("tie1_i", 1'b0, 1'b0, 32'h2000_0000, '0, R2);

        // Third simultaneous pair: D again, then I
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h2100_0000;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h3100_0040;
        tick();
        serve("tie2_d", 1'b1, 1'b0, 32'h3100_0040, '0, R3);
        tick();
        serve("tie2_i", 1'b0, 1'b0, 32'h2100_0000, '0, R4);

        // D read and write together -> treated as a write
        d_pmem_read    = 1'b1;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h4000_0010;
        d_pmem_wdata   = W3;
        tick();
        serve("d_rw", 1'b1, 1'b1, 32'h4000_0000, W3, R5);

        // Reset pulse while BUSY_D, late mem_resp afterwards
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h5000_0000;
        tick();
        chk_eq("mid_rst_busy", 256'(mem_read), 256'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_eq("mid_rst_async_drop", 256'({mem_read, mem_write}), 256'd0);
        d_pmem_read = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        mem_resp  = 1'b1;
        mem_rdata = JUNK;
        tick();
        mem_resp  = 1'b0;
        chk_eq("late_resp_no_client", 256'({i_pmem_resp, d_pmem_resp}), 256'd0);
        chk_eq("late_resp_no_mem",    256'({mem_read, mem_write}), 256'd0);
        chk_eq("late_resp_line",      d_pmem_rdata, 256'd0);

        // last_grant restored to I by reset: D wins the tie
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h6000_0000;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h7000_0000;
        tick();
        serve("rst_tie_d", 1'b1, 1'b0, 32'h7000_0000, '0, R6);
        tick();
        serve("rst_tie_i", 1'b0, 1'b0, 32'h6000_0000, '0, R1);

        // Spurious mem_resp in IDLE
        mem_resp  = 1'b1;
        mem_rdata = JUNK;
        tick();
        mem_resp  = 1'b0;
        chk_eq("spur_no_resp",  256'({i_pmem_resp, d_pmem_resp}), 256'd0);
        chk_eq("spur_no_mem",   256'({mem_read, mem_write}), 256'd0);
        chk_eq("spur_line_kept", i_pmem_rdata, R1);
        tick();
        chk_eq("spur_still_idle", 256'({i_pmem_resp, d_pmem_resp}), 256'd0);
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h7100_0000;
        tick();
        serve("spur_then_d", 1'b1, 1'b0, 32'h7100_0000, '0, R2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
